// File: rtl/moving_sum_sub_pkg.sv
// Shared definitions for the STFT front-end datapath: window FSM encoding
// and the default sample word length / window depth.
package moving_sum_sub_pkg;

    // Default sample width and window depth used across the STFT datapath.
    localparam int STFT_WL    = 8;
    localparam int STFT_LOG2D = 2;

    // FILL: window still collecting its first DEPTH samples.
    // RUN : window full, every accept retires the oldest sample.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } win_state_t;

endpackage : moving_sum_sub_pkg

// File: rtl/moving_sum_sub_if.sv
// Sample-stream bundle of the moving-sum block: strobe, clear and sample
// in, registered window sum with its valid/full flags out.
interface moving_sum_sub_if
    import moving_sum_sub_pkg::*;
#(
    parameter int WL    = STFT_WL,
    parameter int LOG2D = STFT_LOG2D
);

    logic                        iEN;
    logic                        iCLR;
    logic signed [WL-1:0]        idata;
    logic signed [WL+LOG2D-1:0]  odata;
    logic                        oVALID;
    logic                        oFULL;

    // Sample producer / result consumer side.
    modport master (
        output iEN,
        output iCLR,
        output idata,
        input  odata,
        input  oVALID,
        input  oFULL
    );

    // Moving-sum block side.
    modport slave (
        input  iEN,
        input  iCLR,
        input  idata,
        output odata,
        output oVALID,
        output oFULL
    );

endinterface : moving_sum_sub_if

// File: rtl/moving_sum_sub_window_buf.sv
// Circular sample store for the moving sum: one synchronous write port and
// one asynchronous read port sharing the same address. No reset, so it maps
// onto distributed RAM; stale contents are masked by the FILL state upstream.
module window_buf
    import moving_sum_sub_pkg::*;
#(
    parameter int WL    = STFT_WL,
    parameter int LOG2D = STFT_LOG2D
) (
    input  logic                  iCLK,
    input  logic                  we_i,
    input  logic [LOG2D-1:0]      addr_i,
    input  logic signed [WL-1:0]  wdata_i,
    output logic signed [WL-1:0]  rdata_o
);

    localparam int DEPTH = 2 ** LOG2D;

    logic signed [WL-1:0] mem_q [DEPTH];

    // Store the accepted sample at the write pointer.
    always_ff @(posedge iCLK) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read-before-write: the entry at the pointer is the sample leaving the window.
    assign rdata_o = mem_q[addr_i];

endmodule : window_buf

// File: rtl/moving_sum_sub.sv
// Moving sum over the last 2**LOG2D accepted signed samples. A running
// accumulator adds each new sample and, once the window is full, subtracts
// the sample it displaces from the circular buffer. One-cycle latency.
module moving_sum_sub
    import moving_sum_sub_pkg::*;
#(
    parameter int WL    = STFT_WL,
    parameter int LOG2D = STFT_LOG2D
) (
    input  logic               iCLK,
    input  logic               iRSTn,
    moving_sum_sub_if.slave    bus
);

    localparam int DEPTH = 2 ** LOG2D;
    localparam int SW    = WL + LOG2D;
    localparam logic [LOG2D:0] CNT_LAST = (LOG2D + 1)'(DEPTH - 1);

    // Widen a sample to the accumulator width, preserving its sign.
    function automatic logic signed [SW-1:0] sext(input logic signed [WL-1:0] x);
        return {{LOG2D{x[WL-1]}}, x};
    endfunction

    // Accumulator update: add the incoming sample, retire the oldest when running.
    // The sum of DEPTH WL-bit samples always fits SW bits, so no saturation.
    function automatic logic signed [SW-1:0] next_sum(
        input logic signed [SW-1:0] acc,
        input logic signed [WL-1:0] din,
        input logic signed [WL-1:0] dold,
        input logic                 run
    );
        logic signed [SW-1:0] add_v;
        logic signed [SW-1:0] sub_v;
        add_v = sext(din);
        sub_v = run ? sext(dold) : '0;
        return acc + add_v - sub_v;
    endfunction

    win_state_t            state_q,  state_d;
    logic [LOG2D-1:0]      wr_ptr_q, wr_ptr_d;
    logic [LOG2D:0]        count_q,  count_d;
    logic signed [SW-1:0]  odata_q,  odata_d;
    logic                  ovalid_q, ovalid_d;
    logic                  ofull_q,  ofull_d;

    logic                  accept;
    logic signed [WL-1:0]  oldest;

    // Clear wins over the strobe; a sample on a clearing edge is dropped.
    assign accept = bus.iEN & ~bus.iCLR;

    window_buf #(
        .WL    (WL),
        .LOG2D (LOG2D)
    ) u_window_buf (
        .iCLK    (iCLK),
        .we_i    (accept),
        .addr_i  (wr_ptr_q),
        .wdata_i (bus.idata),
        .rdata_o (oldest)
    );

    // Next-state for pointer, fill counter, FSM, accumulator and flags.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        odata_d  = odata_q;
        ovalid_d = 1'b0;
        if (bus.iCLR) begin
            state_d  = FILL;
            wr_ptr_d = '0;
            count_d  = '0;
            odata_d  = '0;
        end else if (bus.iEN) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            odata_d  = next_sum(odata_q, bus.idata, oldest, state_q == RUN);
            if (state_q == FILL) begin
                count_d = count_q + 1'b1;
                if (count_q == CNT_LAST) begin
                    state_d  = RUN;
                    ovalid_d = 1'b1;
                end
            end else begin
                ovalid_d = 1'b1;
            end
        end
        ofull_d = (state_d == RUN);
    end

    // Register all window state and outputs; reset discards the window.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            count_q  <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            ofull_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ofull_q  <= ofull_d;
        end
    end

    assign bus.odata  = odata_q;
    assign bus.oVALID = ovalid_q;
    assign bus.oFULL  = ofull_q;

endmodule : moving_sum_sub

// File: tb/tb_moving_sum_sub.sv
// Directed bench for moving_sum_sub with WL=8, DEPTH=4.
module tb_moving_sum_sub;

    localparam int WL    = 8;
    localparam int LOG2D = 2;
    localparam int SW    = WL + LOG2D;

    logic iCLK;
    logic iRSTn;

    moving_sum_sub_if #(.WL(WL), .LOG2D(LOG2D)) bus ();

    moving_sum_sub #(.WL(WL), .LOG2D(LOG2D)) dut (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Drive one cycle of inputs at the falling edge, return 1 ns after the rising edge.
    task automatic drive(input logic en, input logic clr, input int d);
        @(negedge iCLK);
        bus.iEN   = en;
        bus.iCLR  = clr;
        bus.idata = WL'(d);
        @(posedge iCLK);
        #1;
    endtask

    task automatic test_reset();
        bus.iEN = 1'b0; bus.iCLR = 1'b0; bus.idata = '0;
        iRSTn = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        checks++; if (bus.odata !== SW'(0)) begin errors++; $display("FAIL reset_odata got=%0d exp=0", $signed(bus.odata)); end
        checks++; if (bus.oVALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.oVALID); end
        checks++; if (bus.oFULL !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.oFULL); end
        @(negedge iCLK);
        iRSTn = 1'b1;
    endtask

    // 1,2,3,4 fill then 5..9 back-to-back in RUN across pointer wraps.
    task automatic test_fill_run();
        int din [9]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        int exps[9]  = '{1, 3, 6, 10, 14, 18, 22, 26, 30};
        logic vexp[9] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, din[i]);
            checks++; if ($signed(bus.odata) !== SW'(exps[i])) begin errors++; $display("FAIL fill_run_odata[%0d] got=%0d exp=%0d", i, $signed(bus.odata), exps[i]); end
            checks++; if (bus.oVALID !== vexp[i]) begin errors++; $display("FAIL fill_run_valid[%0d] got=%b exp=%b", i, bus.oVALID, vexp[i]); end
            checks++; if (bus.oFULL !== vexp[i]) begin errors++; $display("FAIL fill_run_full[%0d] got=%b exp=%b", i, bus.oFULL, vexp[i]); end
        end
        drive(1'b0, 1'b0, 0);
        checks++; if ($signed(bus.odata) !== SW'(30)) begin errors++; $display("FAIL idle_hold got=%0d exp=30", $signed(bus.odata)); end
        checks++; if (bus.oVALID !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", bus.oVALID); end
        checks++; if (bus.oFULL !== 1'b1) begin errors++; $display("FAIL idle_full got=%b exp=1", bus.oFULL); end
    endtask

    // Extreme negative window then a positive sample.
    task automatic test_signed();
        int din [5] = '{-128, -128, -128, -128, 127};
        int exps[5] = '{-128, -256, -384, -512, -257};
        logic vexp[5] = '{0, 0, 0, 1, 1};
        drive(1'b0, 1'b1, 0);
        checks++; if (bus.odata !== SW'(0)) begin errors++; $display("FAIL signed_clr got=%0d exp=0", $signed(bus.odata)); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, din[i]);
            checks++; if ($signed(bus.odata) !== SW'(exps[i])) begin errors++; $display("FAIL signed_odata[%0d] got=%0d exp=%0d", i, $signed(bus.odata), exps[i]); end
            checks++; if (bus.oVALID !== vexp[i]) begin errors++; $display("FAIL signed_valid[%0d] got=%b exp=%b", i, bus.oVALID, vexp[i]); end
        end
    endtask

    // Strobe gaps: 1,_,2,_,_,3,4.
    task automatic test_gaps();
        logic en [7]  = '{1, 0, 1, 0, 0, 1, 1};
        int din [7]   = '{1, 99, 2, 99, 99, 3, 4};
        int exps[7]   = '{1, 1, 3, 3, 3, 6, 10};
        logic vexp[7] = '{0, 0, 0, 0, 0, 0, 1};
        drive(1'b0, 1'b1, 0);
        for (int i = 0; i < 7; i++) begin
            drive(en[i], 1'b0, din[i]);
            checks++; if ($signed(bus.odata) !== SW'(exps[i])) begin errors++; $display("FAIL gaps_odata[%0d] got=%0d exp=%0d", i, $signed(bus.odata), exps[i]); end
            checks++; if (bus.oVALID !== vexp[i]) begin errors++; $display("FAIL gaps_valid[%0d] got=%b exp=%b", i, bus.oVALID, vexp[i]); end
        end
    endtask

    // Clear in RUN with a live strobe, then refill with ones.
    task automatic test_clear();
        int exps[4] = '{1, 2, 3, 4};
        logic vexp[4] = '{0, 0, 0, 1};
        drive(1'b1, 1'b1, 9);
        checks++; if (bus.odata !== SW'(0)) begin errors++; $display("FAIL clear_odata got=%0d exp=0", $signed(bus.odata)); end
        checks++; if (bus.oFULL !== 1'b0) begin errors++; $display("FAIL clear_full got=%b exp=0", bus.oFULL); end
        checks++; if (bus.oVALID !== 1'b0) begin errors++; $display("FAIL clear_valid got=%b exp=0", bus.oVALID); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1);
            checks++; if ($signed(bus.odata) !== SW'(exps[i])) begin errors++; $display("FAIL refill_odata[%0d] got=%0d exp=%0d", i, $signed(bus.odata), exps[i]); end
            checks++; if (bus.oVALID !== vexp[i]) begin errors++; $display("FAIL refill_valid[%0d] got=%b exp=%b", i, bus.oVALID, vexp[i]); end
        end
    endtask

    // Asynchronous reset mid-window, then a fresh window of 2s.
    task automatic test_async_reset();
        int exps[4] = '{2, 4, 6, 8};
        logic vexp[4] = '{0, 0, 0, 1};
        drive(1'b1, 1'b0, 5);
        drive(1'b1, 1'b0, 5);
        bus.iEN = 1'b0;
        #2;
        iRSTn = 1'b0;
        #1;
        checks++; if (bus.odata !== SW'(0)) begin errors++; $display("FAIL arst_odata got=%0d exp=0", $signed(bus.odata)); end
        checks++; if (bus.oFULL !== 1'b0) begin errors++; $display("FAIL arst_full got=%b exp=0", bus.oFULL); end
        checks++; if (bus.oVALID !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", bus.oVALID); end
        @(negedge iCLK);
        iRSTn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2);
            checks++; if ($signed(bus.odata) !== SW'(exps[i])) begin errors++; $display("FAIL arst_refill_odata[%0d] got=%0d exp=%0d", i, $signed(bus.odata), exps[i]); end
            checks++; if (bus.oVALID !== vexp[i]) begin errors++; $display("FAIL arst_refill_valid[%0d] got=%b exp=%b", i, bus.oVALID, vexp[i]); end
        end
        drive(1'b1, 1'b0, 6);
        checks++; if ($signed(bus.odata) !== SW'(12)) begin errors++; $display("FAIL arst_run got=%0d exp=12", $signed(bus.odata)); end
    endtask

    initial begin
        iRSTn = 1'b1;
        test_reset();
        test_fill_run();
        test_signed();
        test_gaps();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_moving_sum_sub
